// File: rtl/tomasula_types.sv
// Shared Tomasulo types: dispatch control word, ALU opcode/funct encodings,
// reservation-station FSM state and the captured-operand record.
// No ports (package).
package tomasula_types;

    localparam int unsigned RsRobDepth = 8;
    localparam int unsigned RsTagW     = $clog2(RsRobDepth);
    localparam int unsigned RsNumCdb   = 2;

    // RV32I integer opcodes handled by the ALU stations
    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcOpImm = 7'b0010011;

    localparam logic [2:0] F3AddSub = 3'b000;
    localparam logic [2:0] F3Sll    = 3'b001;
    localparam logic [2:0] F3Slt    = 3'b010;
    localparam logic [2:0] F3Sltu   = 3'b011;
    localparam logic [2:0] F3Xor    = 3'b100;
    localparam logic [2:0] F3Shr    = 3'b101;
    localparam logic [2:0] F3Or     = 3'b110;
    localparam logic [2:0] F3And    = 3'b111;

    // funct7 value selecting SUB / SRA / SRAI
    localparam logic [6:0] F7Alt = 7'b0100000;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        src2_valid;   // src2 is the immediate in src2_data
        logic [31:0] src2_data;
    } ctl_word;

    typedef enum logic [1:0] {
        RsIdle,
        RsWait,
        RsExec,
        RsBcast
    } rs_state_t;

    typedef struct packed {
        logic              rdy;
        logic [RsTagW-1:0] tag;
        logic [31:0]       data;
    } rs_operand_t;

endpackage

// File: rtl/alu_unit.sv
// Combinational RV32I integer ALU, shared with the branch station for compares.
// Ports: op (opcode), funct3, funct7, a, b -> y.
// SUB only for register-register ops; SRA/SRAI selected by funct7 for both forms.
module alu_unit
    import tomasula_types::*;
(
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic       is_sub;
    logic       is_sra;
    logic [4:0] shamt;

    assign is_sub = (op == OpcOp) && (funct7 == F7Alt);
    assign is_sra = (funct7 == F7Alt);
    assign shamt  = b[4:0];

    always_comb begin
        y = '0;
        unique case (funct3)
            F3AddSub: y = is_sub ? (a - b) : (a + b);
            F3Sll:    y = a << shamt;
            F3Slt:    y = {31'b0, $signed(a) < $signed(b)};
            F3Sltu:   y = {31'b0, a < b};
            F3Xor:    y = a ^ b;
            F3Shr:    y = is_sra ? 32'($signed(a) >>> shamt) : (a >> shamt);
            F3Or:     y = a | b;
            F3And:    y = a & b;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/alu_res_station.sv
// Single-entry ALU reservation station with its own ALU.
// Captures operands (regfile / immediate / same-cycle CDB bypass) on load_i,
// snoops the CDB lanes for missing tags, executes for one cycle, then holds
// cdb_req_o with a stable tag/result until cdb_gnt_i.
// Ports: clk_i, reset_n_i (async active-low), flush_i, load_i, ctl_i, rob_tag_i,
//   rs1/rs2 {rdy,data,tag}, cdb_{vld,tag,data}_i, cdb_gnt_i;
//   empty_o, cdb_req_o, res_tag_o, res_data_o.
// Build option RS_PERF_CNT_EN: adds saturating stall_cnt_o (cycles in WAIT)
//   and busy_cnt_o (cycles not IDLE), cleared by reset only.
module alu_res_station
    import tomasula_types::*;
#(
    parameter int unsigned ROB_DEPTH = RsRobDepth,
    parameter int unsigned TAG_W     = $clog2(ROB_DEPTH),
    parameter int unsigned NUM_CDB   = RsNumCdb
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     flush_i,
    input  logic                     load_i,
    input  ctl_word                  ctl_i,
    input  logic [TAG_W-1:0]         rob_tag_i,
    input  logic                     rs1_rdy_i,
    input  logic [31:0]              rs1_data_i,
    input  logic [TAG_W-1:0]         rs1_tag_i,
    input  logic                     rs2_rdy_i,
    input  logic [31:0]              rs2_data_i,
    input  logic [TAG_W-1:0]         rs2_tag_i,
    input  logic [NUM_CDB-1:0]       cdb_vld_i,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag_i,
    input  logic [NUM_CDB*32-1:0]    cdb_data_i,
    output logic                     empty_o,
    output logic                     cdb_req_o,
    input  logic                     cdb_gnt_i,
`ifdef RS_PERF_CNT_EN
    output logic [31:0]              stall_cnt_o,
    output logic [31:0]              busy_cnt_o,
`endif
    output logic [TAG_W-1:0]         res_tag_o,
    output logic [31:0]              res_data_o
);

    rs_state_t        state_q, state_d;
    rs_operand_t      op1_q, op1_d, op2_q, op2_d;
    logic [6:0]       opcode_q, opcode_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [6:0]       funct7_q, funct7_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      res_q, res_d;
    logic [31:0]      alu_y;
    rs_operand_t      ld1, ld2;

    // Resolve a pending operand against the CDB; walking lanes high-to-low
    // leaves the lowest-index match as the winner.
    function automatic rs_operand_t snoop(rs_operand_t cur);
        rs_operand_t r;
        r = cur;
        if (!cur.rdy) begin
            for (int i = int'(NUM_CDB) - 1; i >= 0; i--) begin
                if (cdb_vld_i[i] && (cdb_tag_i[i*TAG_W +: TAG_W] == cur.tag)) begin
                    r.rdy  = 1'b1;
                    r.data = cdb_data_i[i*32 +: 32];
                end
            end
        end
        return r;
    endfunction

    // Dispatch-cycle candidates, including the same-cycle CDB bypass
    always_comb begin
        ld1 = snoop('{rdy: rs1_rdy_i, tag: rs1_tag_i, data: rs1_data_i});
        if (ctl_i.src2_valid) begin
            ld2 = '{rdy: 1'b1, tag: '0, data: ctl_i.src2_data};
        end else begin
            ld2 = snoop('{rdy: rs2_rdy_i, tag: rs2_tag_i, data: rs2_data_i});
        end
    end

    alu_unit u_alu (
        .op     (opcode_q),
        .funct3 (funct3_q),
        .funct7 (funct7_q),
        .a      (op1_q.data),
        .b      (op2_q.data),
        .y      (alu_y)
    );

    always_comb begin
        state_d   = state_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        opcode_d  = opcode_q;
        funct3_d  = funct3_q;
        funct7_d  = funct7_q;
        tag_d     = tag_q;
        res_d     = res_q;
        cdb_req_o = 1'b0;
        unique case (state_q)
            RsIdle: begin
                if (load_i && !flush_i) begin
                    opcode_d = ctl_i.opcode;
                    funct3_d = ctl_i.funct3;
                    funct7_d = ctl_i.funct7;
                    tag_d    = rob_tag_i;
                    op1_d    = ld1;
                    op2_d    = ld2;
                    state_d  = (ld1.rdy && ld2.rdy) ? RsExec : RsWait;
                end
            end
            RsWait: begin
                op1_d = snoop(op1_q);
                op2_d = snoop(op2_q);
                if (op1_d.rdy && op2_d.rdy) begin
                    state_d = RsExec;
                end
            end
            RsExec: begin
                res_d   = alu_y;
                state_d = RsBcast;
            end
            RsBcast: begin
                cdb_req_o = 1'b1;
                if (cdb_gnt_i) begin
                    state_d = RsIdle;
                end
            end
            default: state_d = RsIdle;
        endcase
        // Flush wins over dispatch and grant, and kills the request this cycle
        if (flush_i) begin
            state_d   = RsIdle;
            cdb_req_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= RsIdle;
            op1_q    <= '0;
            op2_q    <= '0;
            opcode_q <= '0;
            funct3_q <= '0;
            funct7_q <= '0;
            tag_q    <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            opcode_q <= opcode_d;
            funct3_q <= funct3_d;
            funct7_q <= funct7_d;
            tag_q    <= tag_d;
            res_q    <= res_d;
        end
    end

    assign empty_o    = (state_q == RsIdle);
    assign res_tag_o  = tag_q;
    assign res_data_o = res_q;

`ifdef RS_PERF_CNT_EN
    logic [31:0] stall_q, busy_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stall_q <= '0;
            busy_q  <= '0;
        end else begin
            if (state_q == RsWait && stall_q != '1) begin
                stall_q <= stall_q + 32'd1;
            end
            if (state_q != RsIdle && busy_q != '1) begin
                busy_q <= busy_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_q;
    assign busy_cnt_o  = busy_q;
`endif

endmodule

// File: tb/tb_alu_res_station.sv
// Directed self-checking bench for alu_res_station with a result scoreboard.
module tb_alu_res_station;
    import tomasula_types::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0, load = 1'b0, gnt = 1'b0;
    ctl_word     ctl = '0;
    logic [2:0]  rob_tag = '0, rs1_tag = '0, rs2_tag = '0;
    logic        rs1_rdy = 1'b0, rs2_rdy = 1'b0;
    logic [31:0] rs1_data = '0, rs2_data = '0;
    logic [1:0]  cdb_vld = '0;
    logic [5:0]  cdb_tag = '0;
    logic [63:0] cdb_data = '0;
    logic        empty, req;
    logic [2:0]  res_tag;
    logic [31:0] res_data;
`ifdef RS_PERF_CNT_EN
    logic [31:0] stall_cnt, busy_cnt;
`endif

    int tests = 0;
    int fails = 0;
    logic allow_busy_load = 1'b0;

    typedef struct {
        logic [2:0]  tag;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_res_station dut (
        .clk_i      (clk),
        .reset_n_i  (rst_n),
        .flush_i    (flush),
        .load_i     (load),
        .ctl_i      (ctl),
        .rob_tag_i  (rob_tag),
        .rs1_rdy_i  (rs1_rdy),
        .rs1_data_i (rs1_data),
        .rs1_tag_i  (rs1_tag),
        .rs2_rdy_i  (rs2_rdy),
        .rs2_data_i (rs2_data),
        .rs2_tag_i  (rs2_tag),
        .cdb_vld_i  (cdb_vld),
        .cdb_tag_i  (cdb_tag),
        .cdb_data_i (cdb_data),
        .empty_o    (empty),
        .cdb_req_o  (req),
        .cdb_gnt_i  (gnt),
`ifdef RS_PERF_CNT_EN
        .stall_cnt_o(stall_cnt),
        .busy_cnt_o (busy_cnt),
`endif
        .res_tag_o  (res_tag),
        .res_data_o (res_data)
    );

    // Dispatch into a busy station is a protocol error unless a step intends it
    always @(negedge clk) begin
        if (rst_n && load && !empty && !flush && !allow_busy_load) begin
            fails++;
            $error("FAIL protocol: load_i while busy observed=1 expected=0");
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa;
        sa = a;
        case (f3)
            3'd0: return (op == OpcOp && f7 == 7'h20) ? a + ~b + 32'd1 : a + b;
            3'd1: return a << b[4:0];
            3'd2: return (sa < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return (f7 == 7'h20) ? 32'(sa >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic set_lane(input int lane, input logic [2:0] t, input logic [31:0] d);
        cdb_vld[lane] = 1'b1;
        cdb_tag[lane*3 +: 3] = t;
        cdb_data[lane*32 +: 32] = d;
    endtask

    task automatic clear_cdb();
        cdb_vld = '0;
        cdb_tag = '0;
        cdb_data = '0;
    endtask

    // Drive one dispatch and advance past its load edge
    task automatic dispatch(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic imm_v, input logic [31:0] imm, input logic [2:0] tag,
                            input logic r1r, input logic [31:0] r1d, input logic [2:0] r1t,
                            input logic r2r, input logic [31:0] r2d, input logic [2:0] r2t);
        ctl = '{opcode: op, funct3: f3, funct7: f7, src2_valid: imm_v, src2_data: imm};
        rob_tag = tag;
        rs1_rdy = r1r; rs1_data = r1d; rs1_tag = r1t;
        rs2_rdy = r2r; rs2_data = r2d; rs2_tag = r2t;
        load = 1'b1;
        step();
        load = 1'b0;
        rs1_rdy = 1'b0; rs2_rdy = 1'b0;
        rs1_data = 32'hDEAD_BEEF; rs2_data = 32'hDEAD_BEEF;
    endtask

    // Wait (bounded) for the request, check against the scoreboard, grant it
    task automatic grant_and_check(input string name);
        exp_t e;
        int n = 0;
        while (!req && n < 20) begin
            step();
            n++;
        end
        chk({name, "_req"}, 32'(req), 32'd1);
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({name, "_tag"}, 32'(res_tag), 32'(e.tag));
            chk({name, "_data"}, res_data, e.data);
        end
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk({name, "_empty_after"}, 32'(empty), 32'd1);
        chk({name, "_req_after"}, 32'(req), 32'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [2:0]  f3;
        logic [6:0]  f7, op;

        // Reset state
        #2;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_tag", 32'(res_tag), 32'd0);
        chk("rst_data", res_data, 32'd0);
        step(); step();
        @(negedge clk) rst_n = 1'b1;
        step();

        // ADDI: request exactly two cycles after dispatch
        dispatch(OpcOpImm, F3AddSub, 7'h0, 1'b1, 32'd7, 3'd3, 1'b1, 32'd5, 3'd0, 1'b0, 0, 3'd0);
        sb.push_back('{3'd3, 32'd12});
        chk("addi_busy", 32'(empty), 32'd0);
        chk("addi_exec_req", 32'(req), 32'd0);
        step();
        chk("addi_req_at_2", 32'(req), 32'd1);
        grant_and_check("addi");

        // ADD with src1 pending on tag 2, resolved by lane1 at cycle +4
        dispatch(OpcOp, F3AddSub, 7'h0, 1'b0, 0, 3'd5, 1'b0, 0, 3'd2, 1'b1, 32'd1, 3'd0);
        sb.push_back('{3'd5, 32'd10});
        step(); step();
        chk("add_wait_req", 32'(req), 32'd0);
        chk("add_wait_busy", 32'(empty), 32'd0);
        step();
        set_lane(0, 3'd4, 32'd99);
        set_lane(1, 3'd2, 32'd9);
        step();
        clear_cdb();
        chk("add_exec_req", 32'(req), 32'd0);
        step();
        chk("add_req_at_6", 32'(req), 32'd1);
        grant_and_check("add");

        // SRAI with same-cycle bypass from lane0: no WAIT cycles
        set_lane(0, 3'd4, 32'h8000_0000);
        dispatch(OpcOpImm, F3Shr, F7Alt, 1'b1, 32'd4, 3'd1, 1'b0, 0, 3'd4, 1'b0, 0, 3'd0);
        clear_cdb();
        sb.push_back('{3'd1, 32'hF800_0000});
        step();
        chk("srai_req_at_2", 32'(req), 32'd1);
        grant_and_check("srai");

        // SUB with both operands resolved in one broadcast cycle
        dispatch(OpcOp, F3AddSub, F7Alt, 1'b0, 0, 3'd7, 1'b0, 0, 3'd5, 1'b0, 0, 3'd6);
        sb.push_back('{3'd7, 32'd42});
        step();
        set_lane(0, 3'd5, 32'd50);
        set_lane(1, 3'd6, 32'd8);
        step();
        clear_cdb();
        chk("sub_exec_req", 32'(req), 32'd0);
        step();
        chk("sub_req", 32'(req), 32'd1);
        grant_and_check("sub");

        // Both lanes carry the pending tag: lane0 wins
        dispatch(OpcOp, F3And, 7'h0, 1'b0, 0, 3'd2, 1'b0, 0, 3'd7, 1'b1, 32'hFF, 3'd0);
        sb.push_back('{3'd2, 32'h12});
        set_lane(0, 3'd7, 32'h12);
        set_lane(1, 3'd7, 32'h34);
        step();
        clear_cdb();
        grant_and_check("lane_prio");

        // Grant withheld for 3 cycles; a load pulse meanwhile is ignored
        dispatch(OpcOpImm, F3Or, 7'h0, 1'b1, 32'h0F, 3'd1, 1'b1, 32'hF0, 3'd0, 1'b0, 0, 3'd0);
        sb.push_back('{3'd1, 32'hFF});
        step();
        for (int i = 0; i < 3; i++) begin
            chk("hold_req", 32'(req), 32'd1);
            chk("hold_tag", 32'(res_tag), 32'd1);
            chk("hold_data", res_data, 32'hFF);
            if (i == 1) begin
                allow_busy_load = 1'b1;
                ctl = '{opcode: OpcOpImm, funct3: F3AddSub, funct7: 7'h0,
                        src2_valid: 1'b1, src2_data: 32'd1};
                rob_tag = 3'd6;
                rs1_rdy = 1'b1;
                rs1_data = 32'd100;
                load = 1'b1;
            end
            step();
            load = 1'b0;
            rs1_rdy = 1'b0;
            allow_busy_load = 1'b0;
        end
        grant_and_check("hold");
        step();
        chk("hold_load_ignored", 32'(empty), 32'd1);

        // Flush in WAIT; a later broadcast of the old tag must not revive it
        dispatch(OpcOp, F3Xor, 7'h0, 1'b0, 0, 3'd4, 1'b0, 0, 3'd2, 1'b1, 32'd3, 3'd0);
        step();
        flush = 1'b1;
        #1;
        chk("flush_wait_req", 32'(req), 32'd0);
        step();
        flush = 1'b0;
        chk("flush_wait_empty", 32'(empty), 32'd1);
        set_lane(0, 3'd2, 32'd1);
        step();
        clear_cdb();
        chk("flush_wait_stays_idle", 32'(empty), 32'd1);

        // Flush in BCAST with coincident grant and load
        dispatch(OpcOpImm, F3AddSub, 7'h0, 1'b1, 32'd1, 3'd5, 1'b1, 32'd1, 3'd0, 1'b0, 0, 3'd0);
        step();
        chk("flush_bcast_req_pre", 32'(req), 32'd1);
        flush = 1'b1;
        gnt = 1'b1;
        load = 1'b1;
        rs1_rdy = 1'b1;
        #1;
        chk("flush_bcast_req", 32'(req), 32'd0);
        step();
        flush = 1'b0; gnt = 1'b0; load = 1'b0; rs1_rdy = 1'b0;
        chk("flush_bcast_empty", 32'(empty), 32'd1);

        // Load coincident with flush in IDLE is discarded
        flush = 1'b1;
        load = 1'b1;
        rs1_rdy = 1'b1;
        step();
        flush = 1'b0; load = 1'b0; rs1_rdy = 1'b0;
        chk("flush_load_discard", 32'(empty), 32'd1);
        step();
        chk("flush_load_discard_req", 32'(req), 32'd0);

        // ALU sweep, register and immediate forms
        for (int k = 0; k < 16; k++) begin
            f3 = 3'(k % 8);
            op = (k < 8) ? OpcOp : OpcOpImm;
            f7 = ((f3 == 3'd0 || f3 == 3'd5) && ($urandom_range(0, 1) == 1)) ? F7Alt : 7'h0;
            a = $urandom;
            b = (k % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            dispatch(op, f3, f7, (op == OpcOpImm), b, 3'(k), 1'b1, a, 3'd0, 1'b1, b, 3'd0);
            sb.push_back('{3'(k), model(op, f3, f7, a, b)});
            grant_and_check("alu_sweep");
        end

        // Asynchronous reset in BCAST
        dispatch(OpcOpImm, F3AddSub, 7'h0, 1'b1, 32'd9, 3'd6, 1'b1, 32'd9, 3'd0, 1'b0, 0, 3'd0);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("areset_empty", 32'(empty), 32'd1);
        chk("areset_req", 32'(req), 32'd0);
        chk("areset_tag", 32'(res_tag), 32'd0);
        chk("areset_data", res_data, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        step();

`ifdef RS_PERF_CNT_EN
        chk("perf_stall_rst", stall_cnt, 32'd0);
        chk("perf_busy_rst", busy_cnt, 32'd0);
        dispatch(OpcOp, F3Or, 7'h0, 1'b0, 0, 3'd3, 1'b0, 0, 3'd1, 1'b1, 32'h1, 3'd0);
        sb.push_back('{3'd3, 32'h3});
        step();
        set_lane(0, 3'd1, 32'h2);
        step();
        clear_cdb();
        grant_and_check("perf_op");
        chk("perf_stall", stall_cnt, 32'd2);
        chk("perf_busy", busy_cnt, 32'd4);
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
